// File: rtl/z80_bus_mem_if.sv
// Z80 CPU-side bus plus write-log read port for z80_bus_mem.
// The master is the CPU or the bench. The slave is the memory/IO block.
interface z80_bus_mem_if;
    logic        m1_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic [7:0]  di;
    logic        wait_n;
    logic        log_rd;
    logic        log_valid;
    logic        log_io;
    logic [15:0] log_addr;
    logic [7:0]  log_data;
    logic        log_ovf;

    modport master (
        output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, dout, log_rd,
        input  di, wait_n, log_valid, log_io, log_addr, log_data, log_ovf
    );

    modport slave (
        input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, dout, log_rd,
        output di, wait_n, log_valid, log_io, log_addr, log_data, log_ovf
    );
endinterface

// File: rtl/z80_bus_mem.sv
// Z80 memory + I/O space with a wait-state generator and an optional write log.
// The write log FIFO is built only when the macro Z80MEM_WRLOG_EN is defined.
module z80_bus_mem #(
    parameter int MEM_AW    = 16,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 0,
    parameter int LOG_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    z80_bus_mem_if.slave bus
);
    localparam int         MEM_SIZE   = 1 << MEM_AW;
    localparam logic [2:0] MEM_WAIT_C = 3'(MEM_WAIT);
    localparam logic [2:0] IO_WAIT_C  = 3'(IO_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       is_io_reg, is_io_next;

    logic mem_req;
    logic io_req;

    // Refresh and interrupt-acknowledge cycles are excluded here.
    // As a result they never stall the CPU and never write.
    assign mem_req = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);
    assign io_req  = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 3'd0;
            is_io_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            is_io_reg <= is_io_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        is_io_next = is_io_reg;
        case (state_reg)
            S_IDLE: begin
                if (mem_req || io_req) begin
                    is_io_next = !mem_req;
                    cnt_next   = mem_req ? MEM_WAIT_C : IO_WAIT_C;
                    state_next = (cnt_next != 3'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) begin
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: state_next = S_HOLD;
            S_HOLD: begin
                if (bus.mreq_n && bus.iorq_n) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.wait_n = (state_reg != S_WAIT);

    // The arrays and the output registers live on the falling edge.
    // This gives the data half a cycle to settle before the CPU samples it.
    logic [7:0]        mem_array [0:MEM_SIZE-1];
    logic [7:0]        io_array  [0:255];
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        io_addr;
    logic [7:0]        mem_q_reg;
    logic [7:0]        io_q_reg;
    logic              committed_reg;
    logic              commit;

    assign mem_addr = bus.A[MEM_AW-1:0];
    assign io_addr  = bus.A[7:0];
    assign commit   = (state_reg == S_ACCESS || state_reg == S_HOLD)
                      && !bus.wr_n && !committed_reg;

    always_ff @(negedge clk) begin
        if (commit && !is_io_reg) begin
            mem_array[mem_addr] <= bus.dout;
        end
        if (commit && is_io_reg) begin
            io_array[io_addr] <= bus.dout;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mem_q_reg     <= 8'h00;
            io_q_reg      <= 8'h00;
            committed_reg <= 1'b0;
        end else begin
            mem_q_reg     <= mem_array[mem_addr];
            io_q_reg      <= io_array[io_addr];
            committed_reg <= (state_reg == S_IDLE) ? 1'b0 : (committed_reg | commit);
        end
    end

    assign bus.di = bus.iorq_n ? mem_q_reg : (bus.m1_n ? io_q_reg : 8'hFF);

`ifdef Z80MEM_WRLOG_EN
    localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    // The commit pulse is stretched to a full clock period.
    // The rising-edge FIFO therefore sees it exactly once.
    logic        log_push_reg;
    logic [24:0] log_entry_reg;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            log_push_reg  <= 1'b0;
            log_entry_reg <= 25'd0;
        end else begin
            log_push_reg  <= commit;
            log_entry_reg <= {is_io_reg, bus.A, bus.dout};
        end
    end

    logic [24:0]  log_array [0:LOG_DEPTH-1];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          ovf_reg;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full    = (count_reg == (PW+1)'(LOG_DEPTH));
    assign pop     = bus.log_rd && (count_reg != '0);
    assign push_ok = log_push_reg && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (log_push_reg && full && !pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            log_array[wr_ptr_reg] <= log_entry_reg;
        end
    end

    // The head entry is masked while empty.
    // This holds the outputs at zero after reset, even though the storage is not reset.
    logic [24:0] head;
    assign head          = (count_reg != '0) ? log_array[rd_ptr_reg] : 25'd0;
    assign bus.log_valid = (count_reg != '0);
    assign bus.log_io    = head[24];
    assign bus.log_addr  = head[23:8];
    assign bus.log_data  = head[7:0];
    assign bus.log_ovf   = ovf_reg;
`else
    logic unused_bits;
    assign unused_bits   = ^{bus.A, bus.log_rd};
    assign bus.log_valid = 1'b0;
    assign bus.log_io    = 1'b0;
    assign bus.log_addr  = 16'h0000;
    assign bus.log_data  = 8'h00;
    assign bus.log_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_mem.sv
// Scoreboard bench for z80_bus_mem: drivers queue expected bus/log responses.
// A negedge monitor pops them when a bus cycle ends or a log entry is consumed.
module tb_z80_bus_mem;
    localparam int MEM_AW    = 12;
    localparam int MEM_WAIT  = 3;
    localparam int IO_WAIT   = 2;
    localparam int LOG_DEPTH = 4;
`ifdef Z80MEM_WRLOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    z80_bus_mem_if bus();

    z80_bus_mem #(
        .MEM_AW(MEM_AW), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         is_read;
        logic [7:0] data;
        int         waits;
    } bus_exp_t;

    bus_exp_t    exp_q[$];
    logic [24:0] log_q[$];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a bus cycle is "active" while a strobe pair is asserted
    bit         act_prev = 1'b0;
    int         wcnt = 0;
    logic [7:0] last_di = 8'h00;

    always @(negedge clk) begin
        bit       act;
        bus_exp_t e;
        #1;
        act = (!bus.mreq_n || !bus.iorq_n) && (!bus.rd_n || !bus.wr_n || !bus.m1_n);
        if (act) begin
            if (!act_prev) wcnt = 0;
            if (!bus.wait_n) wcnt++;
            last_di = bus.di;
        end else if (act_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected bus cycle: got 1 cycle expected none");
            end else begin
                e = exp_q.pop_front();
                chk({e.name, " waits"}, wcnt, e.waits);
                if (e.is_read) chk({e.name, " data"}, last_di, e.data);
            end
        end
        act_prev = act;
        if (bus.log_rd && bus.log_valid) begin
            if (log_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected log entry: got %0h expected none",
                         {bus.log_io, bus.log_addr, bus.log_data});
            end else begin
                chk("log entry", {bus.log_io, bus.log_addr, bus.log_data}, log_q.pop_front());
            end
        end
    end

    task automatic bus_cycle(input string name, input bit io, input bit wr,
                             input logic [15:0] addr, input logic [7:0] data,
                             input logic [7:0] exp_rd, input int exp_waits, input bit logged);
        int n;
        exp_q.push_back('{name, !wr, exp_rd, exp_waits});
        if (wr && logged && LOG_EN) log_q.push_back({io, addr, data});
        bus.A = addr;
        bus.dout = data;
        if (io) bus.iorq_n = 1'b0; else bus.mreq_n = 1'b0;
        if (wr) bus.wr_n = 1'b0; else bus.rd_n = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (!bus.wait_n && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.wait_n) chk({name, " wait bound"}, bus.wait_n, 1);
        @(posedge clk); #1;
        bus.mreq_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic special_cycle(input string name, input bit intack, input logic [15:0] addr,
                                 input logic [7:0] exp_di);
        exp_q.push_back('{name, 1'b1, exp_di, 0});
        bus.A = addr;
        if (intack) begin
            bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        end else begin
            bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; bus.rd_n = 1'b0;
        end
        repeat (4) begin @(posedge clk); #1; end
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.mreq_n = 1'b1; bus.rfsh_n = 1'b1; bus.rd_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain_log();
        int n;
        n = 0;
        bus.log_rd = 1'b1;
        while (bus.log_valid && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        bus.log_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
        bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.rfsh_n = 1'b1;
        bus.A = 16'h0000; bus.dout = 8'h00; bus.log_rd = 1'b0;
        #2;
        chk("reset wait_n", bus.wait_n, 1);
        chk("reset di", bus.di, 8'h00);
        chk("reset log_valid", bus.log_valid, 0);
        chk("reset log_ovf", bus.log_ovf, 0);
        chk("reset log head", {bus.log_io, bus.log_addr, bus.log_data}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        bus_cycle("wr8000", 0, 1, 16'h8000, 8'h5A, 8'h00, 3, 1);
        bus_cycle("rd0000 alias", 0, 0, 16'h0000, 8'h00, 8'h5A, 3, 0);
        bus_cycle("out7F", 1, 1, 16'h007F, 8'hC3, 8'h00, 2, 1);
        bus_cycle("in127F", 1, 0, 16'h127F, 8'h00, 8'hC3, 2, 0);
        bus_cycle("wrF123", 0, 1, 16'hF123, 8'h77, 8'h00, 3, 1);
        bus_cycle("rd0123", 0, 0, 16'h0123, 8'h00, 8'h77, 3, 0);
        special_cycle("intack", 1'b1, 16'h007F, 8'hFF);
        bus_cycle("wr0200", 0, 1, 16'h0200, 8'hA1, 8'h00, 3, 1);
        chk("ovf before full push", bus.log_ovf, 0);
        bus_cycle("wr0201 dropped", 0, 1, 16'h0201, 8'hA2, 8'h00, 3, 0);
        chk("ovf after 5th write", bus.log_ovf, LOG_EN);
        bus_cycle("rd0201", 0, 0, 16'h0201, 8'h00, 8'hA2, 3, 0);
        drain_log();
        chk("log empty after drain", bus.log_valid, 0);

        bus.log_rd = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.log_rd = 1'b0;
        chk("log_valid after empty pop", bus.log_valid, 0);
        chk("ovf sticky", bus.log_ovf, LOG_EN);

        special_cycle("refresh", 1'b0, 16'h0123, 8'h77);

        bus_cycle("wr9300", 0, 1, 16'h9300, 8'h11, 8'h00, 3, 1);
        drain_log();

        exp_q.push_back('{"wr9300 abort", 1'b0, 8'h00, 0});
        bus.A = 16'h9300; bus.dout = 8'hEE; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
        @(posedge clk); #1;
        chk("wait_n in WAIT", bus.wait_n, 0);
        reset = 1'b1;
        #1;
        chk("wait_n on reset", bus.wait_n, 1);
        bus.mreq_n = 1'b1; bus.wr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("log empty after abort", bus.log_valid, 0);
        chk("ovf cleared by reset", bus.log_ovf, 0);
        bus_cycle("rd9300 after abort", 0, 0, 16'h9300, 8'h00, 8'h11, 3, 0);
        bus_cycle("rd8000 after reset", 0, 0, 16'h8000, 8'h00, 8'h5A, 3, 0);

        repeat (3) begin @(posedge clk); #1; end
        chk("bus scoreboard drained", exp_q.size(), 0);
        chk("log scoreboard drained", log_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/z80_bus_mem.md
Z80_BUS_MEM -- requirements
Module: z80_bus_mem

Interface
REQ-001 Parameter MEM_AW, default 16: memory address bits; array holds 2^MEM_AW bytes.
REQ-002 Parameter MEM_WAIT, default 0 (range 0..7): wait states inserted on each memory read/write cycle.
REQ-003 Parameter IO_WAIT, default 0 (range 0..7): wait states inserted on each I/O read/write cycle.
REQ-004 Parameter LOG_DEPTH, default 16 (power of 2, 2..256): write-log FIFO entries.
REQ-005 clk  in  1  CPU clock.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  Z80 bus strobes, active-low.
REQ-008 A  in  16  CPU address bus.
REQ-009 dout  in  8  CPU write data.
REQ-010 di  out  8  CPU read data.
REQ-011 wait_n  out  1  wait request to CPU, active-low.
REQ-012 log_rd  in  1  pop one write-log entry.
REQ-013 log_valid  out  1  write log non-empty.
REQ-014 log_io / log_addr / log_data  out  1/16/8  head entry: I/O flag, address, data (first-word-fall-through).
REQ-015 log_ovf  out  1  sticky write-log overflow flag.

Function
REQ-016 Memory array: 2^MEM_AW x 8; I/O array: 256 x 8, indexed by A[7:0].
REQ-017 Arrays are read and written on the falling edge of clk; read data is registered into separate mem/io output registers on that edge.
REQ-018 di = I/O output register while iorq_n=0, otherwise memory output register; di = 8'hFF during interrupt acknowledge (iorq_n=0, m1_n=0).
REQ-019 Address bits above MEM_AW-1 are ignored (aliasing wrap-around).
REQ-020 Memory request = mreq_n=0 and rfsh_n=1 and (rd_n=0 or wr_n=0); refresh cycles never start a transaction.
REQ-021 I/O request = iorq_n=0, m1_n=1, and (rd_n=0 or wr_n=0).
REQ-022 Wait FSM runs on the rising edge of clk with states IDLE, WAIT, ACCESS, HOLD.
REQ-023 IDLE: on a request, load the 3-bit counter with MEM_WAIT or IO_WAIT; go to WAIT if the value is non-zero, else go to ACCESS.
REQ-024 WAIT: wait_n=0; decrement the counter each cycle; at counter=1, go to ACCESS.
REQ-025 ACCESS: wait_n=1; go to HOLD after one cycle.
REQ-026 HOLD: stay until mreq_n=1 and iorq_n=1; then go to IDLE.
REQ-027 wait_n=1 in every state except WAIT; the FSM stalls exactly N cycles for N wait states.
REQ-028 A write commits exactly once per transaction, on the first falling edge in ACCESS (or HOLD) with wr_n=0.
REQ-029 Writes never commit in WAIT.
REQ-030 Each committed write pushes {io, A, dout} into the write log.
REQ-031 Log full plus push without pop: drop the entry and set log_ovf=1 until reset.
REQ-032 Log full plus simultaneous push and pop: both occur; no overflow.
REQ-033 log_rd while the log is empty is ignored.
REQ-034 Interrupt acknowledge never inserts waits, writes, or log entries.

Reset
REQ-035 reset=1 asynchronously forces: FSM=IDLE, counter=0, wait_n=1, log empty, log_valid=0, log_ovf=0, log_io=0, log_addr=0, log_data=0, and both output registers=0.
REQ-036 Array contents are not affected by reset.
REQ-037 Reset asserted mid-transaction aborts the transaction; an uncommitted write is discarded.

Configuration
REQ-038 Macro Z80MEM_WRLOG_EN defined: write log built per REQ-030..033.
REQ-039 Macro Z80MEM_WRLOG_EN undefined: no FIFO storage; log_valid, log_io, log_addr, log_data and log_ovf are constant 0; log_rd is ignored; memory and I/O behaviour are unchanged.

Verification
REQ-040 MEM_WAIT=0, preload mem[0000]=DD, mem[0001]=24; tv80s runs from reset with IX=8CDA, A=06, F=98 -> after 16 clk: IX=8DDA, F=88, PC=0002, R=02, wait_n never 0.
REQ-041 MEM_WAIT=3; CPU executes LD (8000),A with A=5A -> wait_n low for exactly 3 clk during the write cycle; mem[8000]=5A; exactly one log entry {0,8000,5A}.
REQ-042 IO_WAIT=2; CPU executes OUT (7F),A with A=C3 -> io[7F]=C3; log entry {1,007F,C3}; two extra wait cycles.
REQ-043 LOG_DEPTH=4; CPU performs 5 writes with no pops -> log_ovf=1; 4 oldest entries retained; 5th write still lands in memory.
REQ-044 reset asserted during the WAIT state of a write to 9000 (old value 11) -> wait_n=1 immediately; mem[9000]=11; log empty.
REQ-045 MEM_AW=12; write 77 to F123 -> mem[123]=77; read of 0123 returns 77.
